// File: rtl/vga_timing_gen.sv
// Raster timing generator: x/y scan counters plus registered hsync/vsync/video_on strobes.
// Optional VGA_TIMING_PIXDIV_EN: advance on every other clk (100 MHz board clock -> 50 MHz pixel rate).
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 56,
  parameter int H_SYNC   = 120,
  parameter int H_BP     = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 37,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 23,
  parameter int H_POL    = 1,
  parameter int V_POL    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [10:0] x_count,
  output logic [9:0]  y_count,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        pix_tick,
  output logic        line_end,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_VIS      = 11'(H_ACTIVE);
  localparam logic [10:0] HS_FIRST   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_LAST    = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_FIRST   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic        H_ASSERTED = 1'(H_POL);
  localparam logic        V_ASSERTED = 1'(V_POL);

  logic        adv;
  logic [10:0] x_reg, x_next;
  logic [9:0]  y_reg, y_next;
  logic        hsync_reg, vsync_reg, video_on_reg;
  logic        pix_tick_reg, line_end_reg, frame_start_reg;
  logic        hs_active_next, vs_active_next, video_on_next;

`ifdef VGA_TIMING_PIXDIV_EN
  // Toggle starts at 0, so the first advance lands on the 2nd clk after reset release.
  logic div_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg <= 1'b0;
    end else begin
      div_reg <= ~div_reg;
    end
  end
  assign adv = div_reg;
`else
  assign adv = 1'b1;
`endif

  always_comb begin
    x_next = x_reg;
    y_next = y_reg;
    if (x_reg == H_LAST) begin
      x_next = '0;
      y_next = (y_reg == V_LAST) ? '0 : y_reg + 10'd1;
    end else begin
      x_next = x_reg + 11'd1;
    end
  end

  // Strobes decode the next-state counters so they line up with the registered counters.
  assign hs_active_next = (x_next >= HS_FIRST) && (x_next <= HS_LAST);
  assign vs_active_next = (y_next >= VS_FIRST) && (y_next <= VS_LAST);
  assign video_on_next  = (x_next < H_VIS) && (y_next < V_VIS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg           <= '0;
      y_reg           <= '0;
      hsync_reg       <= ~H_ASSERTED;
      vsync_reg       <= ~V_ASSERTED;
      video_on_reg    <= 1'b0;
      pix_tick_reg    <= 1'b0;
      line_end_reg    <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      pix_tick_reg    <= adv;
      line_end_reg    <= adv && (x_next == H_LAST);
      frame_start_reg <= adv && (x_next == '0) && (y_next == '0);
      if (adv) begin
        x_reg        <= x_next;
        y_reg        <= y_next;
        hsync_reg    <= hs_active_next ? H_ASSERTED : ~H_ASSERTED;
        vsync_reg    <= vs_active_next ? V_ASSERTED : ~V_ASSERTED;
        video_on_reg <= video_on_next;
      end
    end
  end

  assign x_count     = x_reg;
  assign y_count     = y_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign video_on    = video_on_reg;
  assign pix_tick    = pix_tick_reg;
  assign line_end    = line_end_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a closed-form tick-count model pushes expected outputs per clk, popped at negedge.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_PIXDIV_EN
  localparam int DIV = 1;
`else
  localparam int DIV = 0;
`endif

  // Reduced-size instance so whole frames fit the cycle budget; inverted polarity.
  localparam int S_HA = 16, S_HFP = 4, S_HSW = 6, S_HBP = 6;
  localparam int S_VA = 12, S_VFP = 3, S_VSW = 2, S_VBP = 3;
  localparam int S_FRAME = (S_HA + S_HFP + S_HSW + S_HBP) * (S_VA + S_VFP + S_VSW + S_VBP);

  typedef struct {
    int x; int y; int hs; int vs; int von; int pt; int le; int fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [10:0] d_x, s_x;
  logic [9:0]  d_y, s_y;
  logic d_hs, d_vs, d_von, d_pt, d_le, d_fs;
  logic s_hs, s_vs, s_von, s_pt, s_le, s_fs;

  vga_timing_gen dut_d (
    .clk(clk), .rst_n(rst_n), .x_count(d_x), .y_count(d_y), .hsync(d_hs), .vsync(d_vs),
    .video_on(d_von), .pix_tick(d_pt), .line_end(d_le), .frame_start(d_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HSW), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VSW), .V_BP(S_VBP),
    .H_POL(0), .V_POL(0)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .x_count(s_x), .y_count(s_y), .hsync(s_hs), .vsync(s_vs),
    .video_on(s_von), .pix_tick(s_pt), .line_end(s_le), .frame_start(s_fs)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit running = 0;
  exp_t q_d[$];
  exp_t q_s[$];
  int hs_cnt0 = 0;
  int fs_cnt_s = 0;
  int von_bad_s = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs after the cyc-th clk edge since reset release, from the tick count alone.
  function automatic exp_t model(input int c, input int ha, input int hfp, input int hsw, input int hbp,
                                 input int va, input int vfp, input int vsw, input int vbp,
                                 input int hp, input int vp);
    exp_t e;
    int ht, vt, n;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    if (DIV == 1) begin
      n    = c / 2;
      e.pt = (c % 2 == 0) ? 1 : 0;
    end else begin
      n    = c;
      e.pt = 1;
    end
    e.x   = n % ht;
    e.y   = (n / ht) % vt;
    e.hs  = (e.x >= ha + hfp && e.x < ha + hfp + hsw) ? hp : 1 - hp;
    e.vs  = (e.y >= va + vfp && e.y < va + vfp + vsw) ? vp : 1 - vp;
    e.von = (n > 0 && e.x < ha && e.y < va) ? 1 : 0;
    e.le  = (e.pt == 1 && e.x == ht - 1) ? 1 : 0;
    e.fs  = (e.pt == 1 && n > 0 && n % (ht * vt) == 0) ? 1 : 0;
    return e;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      cyc = 0;
    end else if (running) begin
      cyc++;
      q_d.push_back(model(cyc, 800, 56, 120, 64, 600, 37, 6, 23, 1, 1));
      q_s.push_back(model(cyc, S_HA, S_HFP, S_HSW, S_HBP, S_VA, S_VFP, S_VSW, S_VBP, 0, 0));
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (q_d.size() > 0) begin
      e = q_d.pop_front();
      check("d.x_count", 32'(d_x), e.x);
      check("d.y_count", 32'(d_y), e.y);
      check("d.hsync", 32'(d_hs), e.hs);
      check("d.vsync", 32'(d_vs), e.vs);
      check("d.video_on", 32'(d_von), e.von);
      check("d.pix_tick", 32'(d_pt), e.pt);
      check("d.line_end", 32'(d_le), e.le);
      check("d.frame_start", 32'(d_fs), e.fs);
      if (d_hs && d_pt && d_y == 10'd0) hs_cnt0++;
      if (d_le) $display("dflt line_end y=%0d x=%0d", d_y, d_x);
    end
    if (q_s.size() > 0) begin
      e = q_s.pop_front();
      check("s.x_count", 32'(s_x), e.x);
      check("s.y_count", 32'(s_y), e.y);
      check("s.hsync", 32'(s_hs), e.hs);
      check("s.vsync", 32'(s_vs), e.vs);
      check("s.video_on", 32'(s_von), e.von);
      check("s.pix_tick", 32'(s_pt), e.pt);
      check("s.line_end", 32'(s_le), e.le);
      check("s.frame_start", 32'(s_fs), e.fs);
      if (s_fs) fs_cnt_s++;
      if (s_von && s_y >= 10'(S_VA)) von_bad_s++;
      if (s_le) $display("small line_end y=%0d", s_y);
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, ".d.x"}, 32'(d_x), 0);
    check({tag, ".d.y"}, 32'(d_y), 0);
    check({tag, ".d.hsync"}, 32'(d_hs), 0);
    check({tag, ".d.vsync"}, 32'(d_vs), 0);
    check({tag, ".d.video_on"}, 32'(d_von), 0);
    check({tag, ".d.pix_tick"}, 32'(d_pt), 0);
    check({tag, ".d.line_end"}, 32'(d_le), 0);
    check({tag, ".d.frame_start"}, 32'(d_fs), 0);
    check({tag, ".s.x"}, 32'(s_x), 0);
    check({tag, ".s.hsync"}, 32'(s_hs), 1);
    check({tag, ".s.vsync"}, 32'(s_vs), 1);
    check({tag, ".s.pix_tick"}, 32'(s_pt), 0);
  endtask

  initial begin
    int run_ticks;
    int n_end;
    int waited;
    run_ticks = (DIV == 1) ? 2 * (2 * 1040 + 120) : (2 * 1040 + 120);

    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_state("rst_hold");
    $display("reset held 5 clk");

    rst_n = 1'b1;
    running = 1'b1;
    repeat (run_ticks) @(negedge clk);
    $display("sweep done after %0d clk", run_ticks);

    check("d.hsync_ticks_line0", 32'(hs_cnt0), 120);
    check("s.video_on_in_vblank", 32'(von_bad_s), 0);
    n_end = (DIV == 1) ? cyc / 2 : cyc;
    check("s.frame_start_count", 32'(fs_cnt_s), 32'(n_end / S_FRAME));

    // Async reset mid-line: wait for x=400, then drop rst_n between clock edges.
    waited = 0;
    while (d_x != 11'd400 && waited < 4 * 1040) begin
      @(negedge clk);
      waited++;
    end
    check("wait_x400", 32'(d_x), 400);
    #2;
    running = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_state("async_rst");
    $display("async reset at x=400 applied at t=%0t", $time);

    repeat (2) @(negedge clk);
    check_reset_state("async_hold");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
